// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;

    localparam int PC_W = 8;
    localparam int INSTR_W = 8;
    localparam logic [INSTR_W-1:0] DEFAULT_HALT_CODE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } if_state_e;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: instruction store with synchronous write and combinational read, no reset
module instr_mem
    import if_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [IMEM_DEPTH];

    // program image write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, fetch FSM and registered instruction output feeding IF/ID
module instr_fetch_stage
    import if_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W = 6,
    parameter logic [INSTR_W-1:0] HALT_CODE = DEFAULT_HALT_CODE
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    Redirect_PC,
    input  logic               Prog_We,
    input  logic [ADDR_W-1:0]  Prog_Addr,
    input  logic [INSTR_W-1:0] Prog_Data,
    output logic [INSTR_W-1:0] Instr_Code,
    output logic               Instr_Valid,
    output logic [PC_W-1:0]    PC_Out,
    output logic               Halted
);

    if_state_e          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               halted_q, halted_d;
    logic [INSTR_W-1:0] mem_rdata;

    instr_mem #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .clk  (Clk),
        .we   (Prog_We && state_q == IDLE),
        .waddr(Prog_Addr),
        .wdata(Prog_Data),
        .raddr(pc_q[ADDR_W-1:0]),
        .rdata(mem_rdata)
    );

    // next state: redirect beats stall, stall freezes everything, halt opcode parks the PC
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        halted_d = halted_q;
        unique case (state_q)
            IDLE: begin
                if (Start) state_d = RUN;
            end
            RUN: begin
                if (Redirect) begin
                    pc_d    = Redirect_PC;
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d  = mem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    if (mem_rdata == HALT_CODE) state_d = HALTED;
                    else pc_d = pc_q + 8'd1;
                end
            end
            HALTED: begin
                instr_d  = '0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers, cleared immediately by reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            halted_q <= halted_d;
        end
    end

    assign Instr_Code  = instr_q;
    assign Instr_Valid = valid_q;
    assign PC_Out      = pc_out_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed scoreboard bench for the fetch stage
module tb_instr_fetch_stage;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       Redirect = 1'b0;
    logic [7:0] Redirect_PC = 8'h00;
    logic       Prog_We = 1'b0;
    logic [5:0] Prog_Addr = 6'd0;
    logic [7:0] Prog_Data = 8'h00;
    logic [7:0] Instr_Code;
    logic       Instr_Valid;
    logic [7:0] PC_Out;
    logic       Halted;

    typedef struct {
        logic       v;
        logic [7:0] c;
        logic [7:0] p;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    instr_fetch_stage dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .Redirect_PC(Redirect_PC),
        .Prog_We    (Prog_We),
        .Prog_Addr  (Prog_Addr),
        .Prog_Data  (Prog_Data),
        .Instr_Code (Instr_Code),
        .Instr_Valid(Instr_Valid),
        .PC_Out     (PC_Out),
        .Halted     (Halted)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, {7'd0, Instr_Valid}, {7'd0, e.v});
        chk({tag, ".code"}, Instr_Code, e.c);
        chk({tag, ".pc_out"}, PC_Out, e.p);
        chk({tag, ".halted"}, {7'd0, Halted}, {7'd0, e.h});
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] c, input logic [7:0] p, input logic h);
        exp_t e;
        sb.push_back('{v: v, c: c, p: p, h: h});
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_all(tag, e);
        Start = 1'b0;
        Stall = 1'b0;
        Redirect = 1'b0;
        Prog_We = 1'b0;
    endtask

    task automatic prog(input logic [5:0] a, input logic [7:0] d);
        Prog_We = 1'b1;
        Prog_Addr = a;
        Prog_Data = d;
        step("prog", 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        check_all({tag, ".async"}, '{v: 1'b0, c: 8'h00, p: 8'h00, h: 1'b0});
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #1;
        check_all("reset", '{v: 1'b0, c: 8'h00, p: 8'h00, h: 1'b0});
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        prog(6'd0, 8'h11);
        prog(6'd1, 8'h22);
        prog(6'd2, 8'h33);
        prog(6'd3, 8'hFF);
        prog(6'd16, 8'hA6);
        prog(6'd17, 8'hA7);
        prog(6'd63, 8'h5C);

        Start = 1'b1;
        step("run.start", 1'b0, 8'h00, 8'h00, 1'b0);
        step("run.i0", 1'b1, 8'h11, 8'h00, 1'b0);
        step("run.i1", 1'b1, 8'h22, 8'h01, 1'b0);
        step("run.i2", 1'b1, 8'h33, 8'h02, 1'b0);
        step("run.halt_instr", 1'b1, 8'hFF, 8'h03, 1'b0);
        for (int i = 0; i < 10; i++) begin
            Start = 1'b1;
            Stall = i[0];
            Redirect = 1'b1;
            Redirect_PC = 8'h20;
            Prog_We = 1'b1;
            Prog_Addr = 6'd0;
            Prog_Data = 8'h99;
            step("halted.hold", 1'b0, 8'h00, 8'h03, 1'b1);
        end
        do_reset("reset_halted");

        Start = 1'b1;
        step("stall.start", 1'b0, 8'h00, 8'h00, 1'b0);
        step("stall.i0", 1'b1, 8'h11, 8'h00, 1'b0);
        step("stall.i1", 1'b1, 8'h22, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            Stall = 1'b1;
            step("stall.frozen", 1'b1, 8'h22, 8'h01, 1'b0);
        end
        step("stall.i2", 1'b1, 8'h33, 8'h02, 1'b0);
        step("stall.halt_instr", 1'b1, 8'hFF, 8'h03, 1'b0);
        step("stall.halted", 1'b0, 8'h00, 8'h03, 1'b1);
        do_reset("reset_halted2");

        Start = 1'b1;
        step("redir.start", 1'b0, 8'h00, 8'h00, 1'b0);
        step("redir.i0", 1'b1, 8'h11, 8'h00, 1'b0);
        Redirect = 1'b1;
        Stall = 1'b1;
        Redirect_PC = 8'h10;
        step("redir.bubble", 1'b0, 8'h00, 8'h00, 1'b0);
        step("redir.target", 1'b1, 8'hA6, 8'h10, 1'b0);
        step("redir.next", 1'b1, 8'hA7, 8'h11, 1'b0);
        Redirect = 1'b1;
        Redirect_PC = 8'h50;
        step("alias.bubble", 1'b0, 8'h00, 8'h11, 1'b0);
        step("alias.target", 1'b1, 8'hA6, 8'h50, 1'b0);
        Redirect = 1'b1;
        Redirect_PC = 8'hFF;
        step("wrap.bubble", 1'b0, 8'h00, 8'h50, 1'b0);
        Prog_We = 1'b1;
        Prog_Addr = 6'd0;
        Prog_Data = 8'h99;
        step("wrap.ff", 1'b1, 8'h5C, 8'hFF, 1'b0);
        step("wrap.00", 1'b1, 8'h11, 8'h00, 1'b0);
        step("wrap.01", 1'b1, 8'h22, 8'h01, 1'b0);
        do_reset("reset_run");

        Start = 1'b1;
        Prog_We = 1'b1;
        Prog_Addr = 6'd5;
        Prog_Data = 8'h77;
        step("we_start", 1'b0, 8'h00, 8'h00, 1'b0);
        step("gate.i0", 1'b1, 8'h11, 8'h00, 1'b0);
        Redirect = 1'b1;
        Redirect_PC = 8'h05;
        step("we_start.bubble", 1'b0, 8'h00, 8'h00, 1'b0);
        step("we_start.data", 1'b1, 8'h77, 8'h05, 1'b0);
        Redirect = 1'b1;
        Redirect_PC = 8'h03;
        step("redir_halt.bubble", 1'b0, 8'h00, 8'h05, 1'b0);
        step("redir_halt.instr", 1'b1, 8'hFF, 8'h03, 1'b0);
        step("redir_halt.halted", 1'b0, 8'h00, 8'h03, 1'b1);
        do_reset("reset_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
